// File: rtl/cmp_count_pipe.sv
// Operand select + unsigned threshold compare feeding a saturating match counter.
// Optional sticky lost-increment flag: define CMP_STICKY_OVF_EN to add the ovf port.
module cmp_count_pipe #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned CNT_W    = 9,
    parameter int unsigned TERM_CNT = 511
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             sel,
    input  logic [WIDTH-1:0] pri_data,
    input  logic [WIDTH-1:0] alt_data,
    input  logic             thr_valid,
    input  logic [WIDTH-1:0] thr_data,
    output logic             thr_ready,
    input  logic             cnt_en,
    input  logic             clr,
    output logic             match_q,
    output logic [CNT_W-1:0] cnt_q,
    output logic             term
`ifdef CMP_STICKY_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [CNT_W-1:0] TermVal = CNT_W'(TERM_CNT);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] thr_q, thr_d;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] op;
    logic             match_d;
    logic             term_q;
    logic             thr_accept;
    logic             count_req;

    // Stage 1: operand select and compare against the currently held threshold.
    always_comb begin
        op      = sel ? alt_data : pri_data;
        match_d = (op >= thr_q);
    end

    assign thr_ready  = (state_q == StIdle) || (state_q == StHold);
    assign thr_accept = thr_valid && thr_ready;
    assign count_req  = match_q && cnt_en;
    assign cnt_inc    = cnt_q + CNT_W'(1);

    // Stage 2: control and counter next state, highest priority first.
    always_comb begin
        state_d = state_q;
        thr_d   = thr_q;
        cnt_d   = cnt_q;
        if (thr_accept) begin
            // A clr in the same cycle is absorbed: the load already zeroes the count.
            thr_d   = thr_data;
            cnt_d   = '0;
            state_d = StArmed;
        end else if (clr) begin
            cnt_d = '0;
            if (state_q == StHold) begin
                state_d = StArmed;
            end
        end else if ((state_q == StArmed) && count_req) begin
            cnt_d = cnt_inc;
            if (cnt_inc == TermVal) begin
                state_d = StHold;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= StIdle;
            thr_q   <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            term_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            term_q  <= (state_d == StHold);
        end
    end

    assign term = term_q;

`ifdef CMP_STICKY_OVF_EN
    logic ovf_q, ovf_d;

    // Records an increment request that arrived while parked at terminal count.
    always_comb begin
        ovf_d = ovf_q;
        if (thr_accept) begin
            ovf_d = 1'b0;
        end else if ((state_q == StHold) && count_req) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
